// File: rtl/sauria_demo_soc_fixture_if.sv
// sauria_demo_soc_fixture_if
// Groups every signal between the boot/EOC fixture and the surrounding bench.
//   slave  : the fixture side (takes start/config/preload-done/scratch,
//            drives SoC reset, boot pins, preload request and EOC status)
//   master : the bench side (mirror image of slave)
interface sauria_demo_soc_fixture_if;
  logic        start_i;
  logic [1:0]  boot_mode_cfg_i;
  logic [1:0]  preload_mode_cfg_i;
  logic        preload_done_i;
  logic [31:0] scratch_i;
  logic        soc_rst_no;
  logic [1:0]  boot_mode_o;
  logic        preload_req_o;
  logic [2:0]  preload_sel_o;
  logic        eoc_o;
  logic [31:0] exit_code_o;
  logic        error_o;
  logic [1:0]  error_code_o;
  logic        finish_o;
  logic [31:0] cfg_sel_o;
  logic        use_dram_o;

  modport slave (
    input  start_i, boot_mode_cfg_i, preload_mode_cfg_i, preload_done_i, scratch_i,
    output soc_rst_no, boot_mode_o, preload_req_o, preload_sel_o, eoc_o,
           exit_code_o, error_o, error_code_o, finish_o, cfg_sel_o, use_dram_o
  );

  modport master (
    output start_i, boot_mode_cfg_i, preload_mode_cfg_i, preload_done_i, scratch_i,
    input  soc_rst_no, boot_mode_o, preload_req_o, preload_sel_o, eoc_o,
           exit_code_o, error_o, error_code_o, finish_o, cfg_sel_o, use_dram_o
  );
endinterface

// File: rtl/sauria_demo_soc_fixture.sv
// sauria_demo_soc_fixture
// Boot sequencer and end-of-computation monitor for the SAURIA demo SoC.
// Validates and latches the boot/preload configuration on start, holds the
// SoC in reset for ResetCycles cycles, requests a preload in idle boot, then
// watches the EOC scratch register and reports exit code / finish / error.
// Ports:
//   clk_i, rst_i : fixture clock, asynchronous active-high reset
//   bus          : slave side of sauria_demo_soc_fixture_if (see interface)
module sauria_demo_soc_fixture #(
  parameter int unsigned SelectedCfg   = 32'd0,
  parameter int unsigned UseDramSys    = 32'd0,
  parameter int unsigned ResetCycles   = 32'd16,
  parameter int unsigned TimeoutCycles = 32'd0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  sauria_demo_soc_fixture_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_HOLD = 3'd1,
    PRELOAD  = 3'd2,
    WAIT_EOC = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } state_e;

  localparam logic [31:0] RESET_CYCLES_C = 32'(ResetCycles);
  localparam logic [31:0] TIMEOUT_C      = 32'(TimeoutCycles);
  // Last WAIT_EOC count value before the timeout fires (unused when disabled).
  localparam logic [31:0] TIMEOUT_LAST_C = (TimeoutCycles == 0) ? 32'd0 : 32'(TimeoutCycles - 1);

  // Channel select is one-hot; the reserved mode maps to no channel.
  function automatic logic [2:0] preload_onehot(input logic [1:0] mode);
    logic [2:0] sel;
    case (mode)
      2'd0:    sel = 3'b001;
      2'd1:    sel = 3'b010;
      2'd2:    sel = 3'b100;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

  state_e      state_r, state_s;
  logic [1:0]  boot_cfg_r, boot_cfg_s;
  logic [1:0]  preload_cfg_r, preload_cfg_s;
  logic [31:0] hold_cnt_r, hold_cnt_s;
  logic [31:0] wait_cnt_r, wait_cnt_s;
  logic        soc_rst_n_r, soc_rst_n_s;
  logic [1:0]  boot_mode_r, boot_mode_s;
  logic        preload_req_r, preload_req_s;
  logic [2:0]  preload_sel_r, preload_sel_s;
  logic        eoc_r, eoc_s;
  logic [31:0] exit_code_r, exit_code_s;
  logic        error_r, error_s;
  logic [1:0]  error_code_r, error_code_s;
  logic        finish_r, finish_s;

  // State and output registers, all cleared asynchronously by rst_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r       <= IDLE;
      boot_cfg_r    <= 2'd0;
      preload_cfg_r <= 2'd0;
      hold_cnt_r    <= 32'd0;
      wait_cnt_r    <= 32'd0;
      soc_rst_n_r   <= 1'b0;
      boot_mode_r   <= 2'd0;
      preload_req_r <= 1'b0;
      preload_sel_r <= 3'd0;
      eoc_r         <= 1'b0;
      exit_code_r   <= 32'd0;
      error_r       <= 1'b0;
      error_code_r  <= 2'd0;
      finish_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      boot_cfg_r    <= boot_cfg_s;
      preload_cfg_r <= preload_cfg_s;
      hold_cnt_r    <= hold_cnt_s;
      wait_cnt_r    <= wait_cnt_s;
      soc_rst_n_r   <= soc_rst_n_s;
      boot_mode_r   <= boot_mode_s;
      preload_req_r <= preload_req_s;
      preload_sel_r <= preload_sel_s;
      eoc_r         <= eoc_s;
      exit_code_r   <= exit_code_s;
      error_r       <= error_s;
      error_code_r  <= error_code_s;
      finish_r      <= finish_s;
    end
  end

  // Next-state and next-output logic; everything holds unless changed.
  always_comb begin
    state_s       = state_r;
    boot_cfg_s    = boot_cfg_r;
    preload_cfg_s = preload_cfg_r;
    hold_cnt_s    = hold_cnt_r;
    wait_cnt_s    = wait_cnt_r;
    soc_rst_n_s   = soc_rst_n_r;
    boot_mode_s   = boot_mode_r;
    preload_req_s = preload_req_r;
    preload_sel_s = preload_sel_r;
    eoc_s         = eoc_r;
    exit_code_s   = exit_code_r;
    error_s       = error_r;
    error_code_s  = error_code_r;
    finish_s      = finish_r;

    case (state_r)
      IDLE: begin
        if (bus.start_i) begin
          boot_cfg_s    = bus.boot_mode_cfg_i;
          preload_cfg_s = bus.preload_mode_cfg_i;
          // Reject bad configurations while the SoC is still held in reset.
          if (bus.boot_mode_cfg_i == 2'd1) begin
            state_s      = ERR;
            error_s      = 1'b1;
            error_code_s = 2'd1;
            finish_s     = 1'b1;
          end else if ((bus.boot_mode_cfg_i == 2'd0) && (bus.preload_mode_cfg_i == 2'd3)) begin
            state_s      = ERR;
            error_s      = 1'b1;
            error_code_s = 2'd2;
            finish_s     = 1'b1;
          end else begin
            state_s     = RST_HOLD;
            hold_cnt_s  = RESET_CYCLES_C;
            boot_mode_s = bus.boot_mode_cfg_i;
          end
        end else begin
          state_s = IDLE;
        end
      end

      RST_HOLD: begin
        // Releasing on the count-1 edge keeps reset low for exactly ResetCycles.
        if (hold_cnt_r <= 32'd1) begin
          hold_cnt_s  = 32'd0;
          soc_rst_n_s = 1'b1;
          wait_cnt_s  = 32'd0;
          if (boot_cfg_r == 2'd0) begin
            state_s       = PRELOAD;
            preload_req_s = 1'b1;
            preload_sel_s = preload_onehot(preload_cfg_r);
          end else begin
            state_s = WAIT_EOC;
          end
        end else begin
          hold_cnt_s = hold_cnt_r - 32'd1;
        end
      end

      PRELOAD: begin
        if (bus.preload_done_i) begin
          state_s       = WAIT_EOC;
          preload_req_s = 1'b0;
          preload_sel_s = 3'd0;
          wait_cnt_s    = 32'd0;
        end else begin
          state_s = PRELOAD;
        end
      end

      WAIT_EOC: begin
        if (bus.scratch_i[0]) begin
          state_s     = DONE;
          exit_code_s = {1'b0, bus.scratch_i[31:1]};
          eoc_s       = 1'b1;
          finish_s    = 1'b1;
        end else if ((TIMEOUT_C != 32'd0) && (wait_cnt_r >= TIMEOUT_LAST_C)) begin
          state_s      = ERR;
          error_s      = 1'b1;
          error_code_s = 2'd3;
          finish_s     = 1'b1;
        end else if (wait_cnt_r != 32'hFFFF_FFFF) begin
          wait_cnt_s = wait_cnt_r + 32'd1;
        end else begin
          wait_cnt_s = wait_cnt_r;
        end
      end

      DONE:    state_s = DONE;
      ERR:     state_s = ERR;
      default: state_s = IDLE;
    endcase
  end

  assign bus.soc_rst_no    = soc_rst_n_r;
  assign bus.boot_mode_o   = boot_mode_r;
  assign bus.preload_req_o = preload_req_r;
  assign bus.preload_sel_o = preload_sel_r;
  assign bus.eoc_o         = eoc_r;
  assign bus.exit_code_o   = exit_code_r;
  assign bus.error_o       = error_r;
  assign bus.error_code_o  = error_code_r;
  assign bus.finish_o      = finish_r;
  assign bus.cfg_sel_o     = 32'(SelectedCfg);
  assign bus.use_dram_o    = (UseDramSys != 0) ? 1'b1 : 1'b0;

endmodule

// File: tb/tb_sauria_demo_soc_fixture.sv
module tb_sauria_demo_soc_fixture;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cnt;

  always #5 clk = ~clk;

  sauria_demo_soc_fixture_if a_if ();
  sauria_demo_soc_fixture_if b_if ();

  sauria_demo_soc_fixture #(.ResetCycles(16), .TimeoutCycles(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(a_if.slave));

  sauria_demo_soc_fixture #(.SelectedCfg(5), .UseDramSys(1), .ResetCycles(4), .TimeoutCycles(100)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(b_if.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    a_if.start_i = 1'b0; a_if.preload_done_i = 1'b0; a_if.scratch_i = 32'd0;
    b_if.start_i = 1'b0; b_if.preload_done_i = 1'b0; b_if.scratch_i = 32'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic start_a(input logic [1:0] boot, input logic [1:0] pre);
    a_if.boot_mode_cfg_i = boot;
    a_if.preload_mode_cfg_i = pre;
    a_if.start_i = 1'b1;
    step();
    a_if.start_i = 1'b0;
  endtask

  // Counts cycles soc_rst_no stays low, starting with the cycle after the start edge.
  task automatic until_release_a(output int n);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (a_if.soc_rst_no === 1'b1) return;
      n++;
    end
  endtask

  initial begin
    a_if.start_i = 1'b0; a_if.boot_mode_cfg_i = 2'd0; a_if.preload_mode_cfg_i = 2'd0;
    a_if.preload_done_i = 1'b0; a_if.scratch_i = 32'd0;
    b_if.start_i = 1'b0; b_if.boot_mode_cfg_i = 2'd0; b_if.preload_mode_cfg_i = 2'd0;
    b_if.preload_done_i = 1'b0; b_if.scratch_i = 32'd0;
    #2 rst = 1'b1;
    #1;
    // Reset values
    chk("rst_soc_rst_no", 32'(a_if.soc_rst_no), 32'd0);
    chk("rst_boot_mode", 32'(a_if.boot_mode_o), 32'd0);
    chk("rst_preload_req", 32'(a_if.preload_req_o), 32'd0);
    chk("rst_eoc_finish", {30'd0, a_if.eoc_o, a_if.finish_o}, 32'd0);
    chk("rst_error", {29'd0, a_if.error_o, a_if.error_code_o}, 32'd0);
    chk("cfg_sel_a", a_if.cfg_sel_o, 32'd0);
    chk("cfg_sel_b", b_if.cfg_sel_o, 32'd5);
    chk("use_dram_b", 32'(b_if.use_dram_o), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Boot 0 / JTAG preload
    start_a(2'd0, 2'd0);
    chk("t1_hold_boot_mode", 32'(a_if.boot_mode_o), 32'd0);
    until_release_a(cnt);
    chk("t1_reset_low_cycles", 32'(cnt), 32'd16);
    chk("t1_preload_req", 32'(a_if.preload_req_o), 32'd1);
    chk("t1_preload_sel", 32'(a_if.preload_sel_o), 32'h1);
    a_if.scratch_i = 32'd1;           // stale EOC bit during preload
    repeat (3) step();
    chk("t1_stale_eoc_ignored", 32'(a_if.eoc_o), 32'd0);
    chk("t1_still_preload", 32'(a_if.preload_req_o), 32'd1);
    a_if.scratch_i = 32'd0;
    a_if.preload_done_i = 1'b1;
    step();
    a_if.preload_done_i = 1'b0;
    chk("t1_req_cleared", {28'd0, a_if.preload_req_o, a_if.preload_sel_o}, 32'd0);
    step();
    chk("t1_no_eoc_yet", 32'(a_if.eoc_o), 32'd0);
    a_if.scratch_i = 32'h0000_0001;
    step();
    chk("t1_eoc", 32'(a_if.eoc_o), 32'd1);
    chk("t1_exit_code", a_if.exit_code_o, 32'd0);
    chk("t1_finish", 32'(a_if.finish_o), 32'd1);
    start_a(2'd2, 2'd1);              // ignored in DONE
    step();
    chk("t1_done_sticky", {29'd0, a_if.eoc_o, a_if.boot_mode_o}, 32'h4);

    // Boot 0 / UART preload, reset mid-preload, restart
    reset_all();
    a_if.scratch_i = 32'h0000_0055;
    start_a(2'd0, 2'd2);
    until_release_a(cnt);
    chk("t2_preload_sel", 32'(a_if.preload_sel_o), 32'h4);
    chk("t2_eoc_ignored", 32'(a_if.eoc_o), 32'd0);
    step();
    rst = 1'b1;
    #1;
    chk("t2_async_rst_outs", {25'd0, a_if.soc_rst_no, a_if.preload_req_o, a_if.preload_sel_o,
                             a_if.boot_mode_o}, 32'd0);
    chk("t2_async_rst_status", {29'd0, a_if.eoc_o, a_if.error_o, a_if.finish_o}, 32'd0);
    step();
    rst = 1'b0;
    start_a(2'd0, 2'd2);
    until_release_a(cnt);
    chk("t2_restart_low_cycles", 32'(cnt), 32'd16);
    chk("t2_restart_sel", 32'(a_if.preload_sel_o), 32'h4);
    a_if.preload_done_i = 1'b1;
    step();
    a_if.preload_done_i = 1'b0;
    chk("t2_wait_no_eoc", 32'(a_if.eoc_o), 32'd0);
    step();
    chk("t2_eoc", 32'(a_if.eoc_o), 32'd1);
    chk("t2_exit_code", a_if.exit_code_o, 32'h2A);

    // Autonomous boot
    reset_all();
    start_a(2'd2, 2'd0);
    chk("t3_boot_mode", 32'(a_if.boot_mode_o), 32'd2);
    until_release_a(cnt);
    chk("t3_reset_low_cycles", 32'(cnt), 32'd16);
    chk("t3_no_preload", {28'd0, a_if.preload_req_o, a_if.preload_sel_o}, 32'd0);
    a_if.scratch_i = 32'hFFFF_FFFF;
    step();
    chk("t3_exit_code", a_if.exit_code_o, 32'h7FFF_FFFF);
    chk("t3_eoc_finish", {30'd0, a_if.eoc_o, a_if.finish_o}, 32'h3);
    chk("t3_boot_mode_kept", 32'(a_if.boot_mode_o), 32'd2);

    // Unsupported boot mode
    reset_all();
    start_a(2'd1, 2'd0);
    chk("t4_error", {29'd0, a_if.error_o, a_if.error_code_o}, 32'h5);
    chk("t4_finish", 32'(a_if.finish_o), 32'd1);
    repeat (20) step();
    chk("t4_soc_held", 32'(a_if.soc_rst_no), 32'd0);
    chk("t4_boot_pins", 32'(a_if.boot_mode_o), 32'd0);

    // Reserved preload mode
    reset_all();
    start_a(2'd0, 2'd3);
    chk("t4b_error", {29'd0, a_if.error_o, a_if.error_code_o}, 32'h6);
    repeat (20) step();
    chk("t4b_soc_held", 32'(a_if.soc_rst_no), 32'd0);

    // Timeout on the second instance (4 reset cycles, 100-cycle timeout)
    reset_all();
    b_if.boot_mode_cfg_i = 2'd2;
    b_if.preload_mode_cfg_i = 2'd0;
    b_if.start_i = 1'b1;
    step();
    b_if.start_i = 1'b0;
    cnt = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (b_if.soc_rst_no === 1'b1) break;
      cnt++;
    end
    chk("t5_reset_low_cycles", 32'(cnt), 32'd4);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      cnt++;
      if (b_if.error_o === 1'b1) break;
    end
    chk("t5_timeout_cycles", 32'(cnt), 32'd100);
    chk("t5_error_code", 32'(b_if.error_code_o), 32'd3);
    chk("t5_finish_no_eoc", {30'd0, b_if.finish_o, b_if.eoc_o}, 32'h2);
    chk("t5_soc_rst_kept", 32'(b_if.soc_rst_no), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sauria_demo_soc_fixture.md
Name: sauria_demo_soc_fixture

Overview:
Boot-sequencing and end-of-computation (EOC) controller for the SAURIA demonstrator SoC simulation environment.
- Latches boot and preload configuration, drives the SoC boot-mode pins and holds the SoC in reset for a fixed time.
- In idle boot, requests a binary preload over the selected channel (JTAG, serial link or UART).
- Then polls the SoC EOC scratch register and reports the exit code and a finish indication to the surrounding bench.

Parameters:
SelectedCfg, 0, simulation configuration index; passed through on cfg_sel_o, no internal effect.
UseDramSys, 0, 1 when the DRAM model replaces the default memory; reflected on use_dram_o.
ResetCycles, 16, number of cycles soc_rst_no is held low after start; minimum 1.
TimeoutCycles, 0, maximum cycles in WAIT_EOC before a timeout error; 0 disables the timeout.

Ports:
clk_i  in  1  fixture clock
rst_i  in  1  asynchronous reset, active-high
start_i  in  1  single-cycle pulse that latches the configuration and starts the sequence
boot_mode_cfg_i  in  2  requested boot mode: 0 idle/preload, 1 SD card, 2/3 autonomous
preload_mode_cfg_i  in  2  requested preload channel: 0 JTAG, 1 serial link, 2 UART, 3 reserved
preload_done_i  in  1  preload agent finished loading and launching the binary
scratch_i  in  32  live value of SoC scratch register 2 (EOC register)
soc_rst_no  out  1  SoC reset, active-low
boot_mode_o  out  2  boot-mode pins to the SoC
preload_req_o  out  1  preload request, level
preload_sel_o  out  3  one-hot channel select: bit0 JTAG, bit1 serial link, bit2 UART
eoc_o  out  1  end of computation reached
exit_code_o  out  32  program exit code
error_o  out  1  sequence aborted
error_code_o  out  2  1 unsupported boot mode, 2 reserved preload mode, 3 timeout
finish_o  out  1  simulation may end
cfg_sel_o  out  32  SelectedCfg constant
use_dram_o  out  1  UseDramSys constant

Behaviour:
- Reset values (asserted immediately and asynchronously, including mid-operation):
  - state IDLE; soc_rst_no=0; boot_mode_o=0; preload_req_o=0; preload_sel_o=0.
  - eoc_o=0; exit_code_o=0; error_o=0; error_code_o=0; finish_o=0; all counters 0.
- FSM states: IDLE, RST_HOLD, PRELOAD, WAIT_EOC, DONE, ERR. All outputs are registered.
- IDLE:
  - On start_i, latch both configuration inputs.
  - Boot mode 1 -> ERR, error code 1.
  - Boot mode 0 with preload mode 3 -> ERR, error code 2.
  - Otherwise -> RST_HOLD with the counter loaded to ResetCycles.
  - Validation happens before the SoC reset is released.
- RST_HOLD:
  - boot_mode_o = latched boot mode from the first RST_HOLD cycle; soc_rst_no stays 0.
  - Counter decrements each cycle.
  - When the counter reaches 0, soc_rst_no rises on the next edge and the state moves on: boot mode 0 -> PRELOAD, else -> WAIT_EOC.
  - soc_rst_no is low for exactly ResetCycles cycles.
- PRELOAD:
  - preload_req_o=1; preload_sel_o one-hot from the latched preload mode.
  - On preload_done_i -> WAIT_EOC; req and sel clear on the same edge.
  - preload_done_i is ignored in every other state.
- WAIT_EOC:
  - Sample scratch_i each cycle.
  - If scratch_i[0]=1: exit_code_o = {1'b0, scratch_i[31:1]} (logical right shift by 1), -> DONE.
  - scratch_i[0] is ignored before WAIT_EOC, so a stale value during preload has no effect.
  - If TimeoutCycles>0 and TimeoutCycles cycles elapse in WAIT_EOC without EOC -> ERR, error code 3. The cycle counter saturates.
- DONE: eoc_o=1, finish_o=1, exit_code_o held. start_i is ignored. Leaves only on reset.
- ERR: error_o=1, finish_o=1, error_code_o held, soc_rst_no keeps its current value. Leaves only on reset.
- start_i outside IDLE is ignored.
- boot_mode_o keeps its value after reset release until the fixture is reset.

Test Plan:
- Boot 0 / preload 0, ResetCycles=16 -> soc_rst_no low 16 cycles, preload_sel_o=001. Done pulse, then scratch_i=0x0000_0001 -> eoc_o=1, exit_code_o=0, finish_o=1.
- Boot 0 / preload 2 with scratch_i=0x0000_0055 -> preload_sel_o=100; after done, exit_code_o=0x2A, eoc_o=1.
- Boot 2 -> no preload_req_o; scratch_i=0xFFFF_FFFF after reset release -> exit_code_o=0x7FFF_FFFF.
- Boot 1 -> error_o=1, error_code_o=1, soc_rst_no never released. Boot 0 / preload 3 -> error_code_o=2.
- TimeoutCycles=100, scratch_i held 0 -> error_code_o=3 after 100 WAIT_EOC cycles. scratch_i[0]=1 during PRELOAD is ignored.
- rst_i asserted during PRELOAD -> all outputs return to reset values immediately; a new start_i restarts the sequence correctly.
